// File: rtl/counter8_scheduler.sv
// counter8_scheduler
//   Round-robin scheduler that hands an external 8-bit loadable counter to one
//   of two requesters. The counter is loaded with the requester's start value
//   and counted up to its end value, wrapping modulo 256. A RUN-cycle watchdog
//   aborts a job that fails to reach its end value.
//
// Ports
//   clk                   system clock, rising edge
//   arst                  asynchronous active-high reset
//   req_a / req_b         level job requests, held until done or abort
//   start_a / start_b     counter start value per requester
//   end_a / end_b         terminal counter value per requester
//   gnt_a / gnt_b         registered grants (at most one high)
//   done_a / done_b       one-cycle job-complete pulses
//   err                   one-cycle pulse on watchdog abort
//   cnt_en                counter increment enable
//   cnt_load              counter load strobe
//   cnt_oe                counter output enable
//   cnt_load_val          counter load value (0 outside LOAD)
//   cnt_value             current counter value fed back
module counter8_scheduler #(
    parameter int unsigned TIMEOUT = 300
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [7:0] start_a,
    input  logic [7:0] start_b,
    input  logic [7:0] end_a,
    input  logic [7:0] end_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       done_a,
    output logic       done_b,
    output logic       err,
    output logic       cnt_en,
    output logic       cnt_load,
    output logic       cnt_oe,
    output logic [7:0] cnt_load_val,
    input  logic [7:0] cnt_value
);

    // Value of the RUN-cycle counter during the TIMEOUT-th RUN cycle.
    localparam logic [9:0] TimeoutLast = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic [7:0] start_q, start_d;
    logic [7:0] end_q, end_d;
    logic       prefer_b_q, prefer_b_d;
    logic [9:0] run_cnt_q, run_cnt_d;
    logic       err_q, err_d;
    logic       req_sel;

    // Request line of whichever requester currently owns the counter.
    assign req_sel = gnt_a_q ? req_a : req_b;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= StIdle;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            start_q    <= 8'd0;
            end_q      <= 8'd0;
            prefer_b_q <= 1'b0;
            run_cnt_q  <= 10'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            start_q    <= start_d;
            end_q      <= end_d;
            prefer_b_q <= prefer_b_d;
            run_cnt_q  <= run_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_a_d    = gnt_a_q;
        gnt_b_d    = gnt_b_q;
        start_d    = start_q;
        end_d      = end_q;
        prefer_b_d = prefer_b_q;
        run_cnt_d  = run_cnt_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // The pointer moves at grant time, so an aborted job still
                // hands priority to the other requester.
                if (req_a && (!req_b || !prefer_b_q)) begin
                    gnt_a_d    = 1'b1;
                    start_d    = start_a;
                    end_d      = end_a;
                    prefer_b_d = 1'b1;
                    state_d    = StLoad;
                end else if (req_b) begin
                    gnt_b_d    = 1'b1;
                    start_d    = start_b;
                    end_d      = end_b;
                    prefer_b_d = 1'b0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (!req_sel) begin
                    gnt_a_d = 1'b0;
                    gnt_b_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    run_cnt_d = 10'd0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (!req_sel) begin
                    gnt_a_d = 1'b0;
                    gnt_b_d = 1'b0;
                    state_d = StIdle;
                end else if (cnt_value == end_q) begin
                    state_d = StDone;
                end else if (run_cnt_q == TimeoutLast) begin
                    gnt_a_d = 1'b0;
                    gnt_b_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    run_cnt_d = run_cnt_q + 10'd1;
                end
            end
            StDone: begin
                gnt_a_d = 1'b0;
                gnt_b_d = 1'b0;
                state_d = StIdle;
            end
            default: begin
                gnt_a_d = 1'b0;
                gnt_b_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        gnt_a        = gnt_a_q;
        gnt_b        = gnt_b_q;
        err          = err_q;
        cnt_load     = (state_q == StLoad);
        cnt_load_val = (state_q == StLoad) ? start_q : 8'd0;
        cnt_en       = (state_q == StRun) && (cnt_value != end_q);
        cnt_oe       = (state_q == StRun) || (state_q == StDone);
        done_a       = (state_q == StDone) && gnt_a_q;
        done_b       = (state_q == StDone) && gnt_b_q;
    end

endmodule

// File: tb/tb_counter8_scheduler.sv
module tb_counter8_scheduler;

    localparam int unsigned TIMEOUT = 300;

    logic       clk = 1'b0;
    logic       arst;
    logic       req_a, req_b;
    logic [7:0] start_a, start_b, end_a, end_b;
    logic       gnt_a, gnt_b, done_a, done_b, err;
    logic       cnt_en, cnt_load, cnt_oe;
    logic [7:0] cnt_load_val, cnt_value;
    logic       stuck;
    logic [7:0] cnt_q;
    logic [15:0] outs;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc, en_n, load_n, done_a_n, done_b_n, err_n, both_n, viol_n;
    int load_cyc, done_cyc, err_cyc;

    always #5 clk = ~clk;

    counter8_scheduler #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .arst         (arst),
        .req_a        (req_a),
        .req_b        (req_b),
        .start_a      (start_a),
        .start_b      (start_b),
        .end_a        (end_a),
        .end_b        (end_b),
        .gnt_a        (gnt_a),
        .gnt_b        (gnt_b),
        .done_a       (done_a),
        .done_b       (done_b),
        .err          (err),
        .cnt_en       (cnt_en),
        .cnt_load     (cnt_load),
        .cnt_oe       (cnt_oe),
        .cnt_load_val (cnt_load_val),
        .cnt_value    (cnt_value)
    );

    // Model of the external 8-bit loadable counter; 'stuck' pins it at 0.
    always @(posedge clk or posedge arst) begin
        if (arst)          cnt_q <= 8'd0;
        else if (stuck)    cnt_q <= 8'd0;
        else if (cnt_load) cnt_q <= cnt_load_val;
        else if (cnt_en)   cnt_q <= cnt_q + 8'd1;
    end
    assign cnt_value = cnt_q;

    assign outs = {gnt_a, gnt_b, done_a, done_b, err, cnt_en, cnt_load, cnt_oe, cnt_load_val};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic clear_stats();
        cyc = 0; en_n = 0; load_n = 0; done_a_n = 0; done_b_n = 0; err_n = 0;
        load_cyc = -1; done_cyc = -1; err_cyc = -1;
    endtask

    // Advance to the next falling edge and accumulate per-cycle observations.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cnt_en) en_n++;
        if (cnt_load) begin load_n++; load_cyc = cyc; end
        if (done_a) begin done_a_n++; done_cyc = cyc; end
        if (done_b) begin done_b_n++; done_cyc = cyc; end
        if (err) begin err_n++; err_cyc = cyc; end
        if (gnt_a && gnt_b) both_n++;
        if ((cnt_load && cnt_en) || (cnt_load && cnt_oe) || (!cnt_load && cnt_load_val != 8'd0)
            || (!gnt_a && !gnt_b && (cnt_oe || cnt_en || cnt_load))
            || (done_a && !gnt_a) || (done_b && !gnt_b))
            viol_n++;
    endtask

    task automatic wait_end(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_a || done_b || err) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;
        int grants;
        logic [2:0] order;
        logic prev_a, prev_b;

        both_n = 0; viol_n = 0;
        clear_stats();
        arst = 1'b1; stuck = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        start_a = 8'd0; start_b = 8'd0; end_a = 8'd0; end_b = 8'd0;
        tick();
        check("reset_outputs", 32'(outs), 32'd0);
        tick();
        arst = 1'b0;
        tick();
        check("idle_outputs", 32'(outs), 32'd0);

        // Basic job A: 10 -> 15
        start_a = 8'd10; end_a = 8'd15; req_a = 1'b1;
        clear_stats();
        tick();
        check("a_gnt", 32'(gnt_a), 32'd1);
        check("a_load", 32'(cnt_load), 32'd1);
        check("a_load_val", 32'(cnt_load_val), 32'd10);
        check("a_oe_in_load", 32'(cnt_oe), 32'd0);
        start_a = 8'd99; end_a = 8'd200;  // must not disturb the running job
        wait_end(50, seen);
        check("a_done_seen", 32'(seen), 32'd1);
        check("a_done_is_a", 32'(done_a), 32'd1);
        check("a_en_cycles", 32'(en_n), 32'd5);
        check("a_load_cycles", 32'(load_n), 32'd1);
        check("a_done_latency", 32'(done_cyc - load_cyc), 32'd7);
        req_a = 1'b0;
        tick();
        check("a_gnt_drop", 32'(gnt_a), 32'd0);
        check("a_done_once", 32'(done_a_n), 32'd1);

        // Round robin from a fresh reset: A, B, A
        arst = 1'b1;
        tick();
        arst = 1'b0;
        start_a = 8'd1; end_a = 8'd3; start_b = 8'd5; end_b = 8'd6;
        req_a = 1'b1; req_b = 1'b1;
        clear_stats();
        grants = 0; order = 3'd0; prev_a = 1'b0; prev_b = 1'b0;
        for (int i = 0; i < 100 && grants < 3; i++) begin
            tick();
            if (gnt_a && !prev_a) begin order = {order[1:0], 1'b0}; grants++; end
            if (gnt_b && !prev_b) begin order = {order[1:0], 1'b1}; grants++; end
            prev_a = gnt_a; prev_b = gnt_b;
        end
        req_a = 1'b0; req_b = 1'b0;
        tick(); tick();
        check("rr_grants", 32'(grants), 32'd3);
        check("rr_order", 32'(order), 32'b010);
        check("rr_done_a", 32'(done_a_n), 32'd1);
        check("rr_done_b", 32'(done_b_n), 32'd1);
        check("rr_both_gnt", 32'(both_n), 32'd0);

        // Wrap on B: 250 -> 3
        start_b = 8'd250; end_b = 8'd3; req_b = 1'b1;
        clear_stats();
        wait_end(50, seen);
        check("wrap_done_seen", 32'(seen), 32'd1);
        check("wrap_done_b", 32'(done_b), 32'd1);
        check("wrap_en_cycles", 32'(en_n), 32'd9);
        check("wrap_done_latency", 32'(done_cyc - load_cyc), 32'd11);
        req_b = 1'b0;
        tick();
        check("wrap_gnt_drop", 32'(gnt_b), 32'd0);
        check("wrap_no_done_a", 32'(done_a_n), 32'd0);

        // start == end
        start_a = 8'd77; end_a = 8'd77; req_a = 1'b1;
        clear_stats();
        wait_end(20, seen);
        check("eq_done_seen", 32'(done_a), 32'd1);
        check("eq_done_latency", 32'(done_cyc - load_cyc), 32'd2);
        check("eq_no_en", 32'(en_n), 32'd0);
        req_a = 1'b0;
        tick();

        // Watchdog: counter stuck at 0, end = 5
        stuck = 1'b1; start_a = 8'd0; end_a = 8'd5; req_a = 1'b1;
        clear_stats();
        wait_end(TIMEOUT + 50, seen);
        check("to_err_seen", 32'(err), 32'd1);
        check("to_err_latency", 32'(err_cyc - load_cyc), 32'(TIMEOUT + 1));
        check("to_gnt_drop", 32'(gnt_a), 32'd0);
        check("to_no_done", 32'(done_a_n), 32'd0);
        req_a = 1'b0; stuck = 1'b0;
        tick();
        check("to_err_once", 32'(err_n), 32'd1);

        // Asynchronous reset in the middle of RUN
        start_a = 8'd0; end_a = 8'd100; req_a = 1'b1;
        clear_stats();
        tick(); tick(); tick(); tick();
        check("arst_pre_run_oe", 32'(cnt_oe), 32'd1);
        #2 arst = 1'b1;
        #1;
        check("arst_outputs", 32'(outs), 32'd0);
        tick();
        check("arst_no_done_err", 32'(done_a_n + err_n), 32'd0);
        arst = 1'b0;
        tick();
        check("arst_regrant", 32'({gnt_a, cnt_load}), 32'b11);
        req_a = 1'b0;
        tick();
        check("load_abort_gnt", 32'({gnt_a, cnt_oe}), 32'd0);

        // Drop req_b during RUN
        start_b = 8'd0; end_b = 8'd100; req_b = 1'b1;
        clear_stats();
        tick(); tick(); tick(); tick();
        check("dropb_running", 32'({gnt_b, cnt_oe}), 32'b11);
        req_b = 1'b0;
        tick();
        check("dropb_idle", 32'({gnt_b, cnt_oe, cnt_en}), 32'd0);
        tick(); tick(); tick();
        check("dropb_no_done", 32'(done_b_n + err_n), 32'd0);
        // Pointer advanced on the aborted B grant, so A wins the tie.
        req_a = 1'b1; req_b = 1'b1;
        tick();
        check("dropb_rr_next_a", 32'({gnt_a, gnt_b}), 32'b10);
        req_a = 1'b0; req_b = 1'b0;
        tick(); tick();

        check("protocol_violations", 32'(viol_n), 32'd0);
        check("never_both_gnt", 32'(both_n), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
